// File: rtl/bce_pkg.sv
// Shared types and helpers for the block copy engine: FSM state encoding,
// word size, default marker value and the burst-length helper.
package bce_pkg;

  localparam int          BYTES_PER_WORD = 4;
  localparam logic [31:0] DEFAULT_MARKER = 32'hAAAA0000;

  typedef enum logic [3:0] {
    IDLE, POLL_GO, POLL_WAIT, POLL_POP, POLL_CHECK, GAP,
    RD_GO, RD_STREAM, RD_WAIT, WR_GO, WR_STREAM, WR_WAIT,
    CLR_GO, CLR_WAIT, DONE
  } bce_state_t;

  // Words in the next burst: the remainder, capped at the burst size.
  function automatic logic [7:0] burst_len(input logic [7:0] remaining,
                                           input logic [7:0] burst);
    return (remaining < burst) ? remaining : burst;
  endfunction

endpackage

// File: rtl/bce_if.sv
// Control/user bundles of the Avalon read and write masters. The engine
// connects through the master modports; the masters connect through slave.
interface bce_rd_if #(parameter int ADDRESSWIDTH = 28, parameter int DATAWIDTH = 32);
  logic                    read_control_done;
  logic                    read_control_fixed_location;
  logic [ADDRESSWIDTH-1:0] read_control_read_base;
  logic [ADDRESSWIDTH-1:0] read_control_read_length;
  logic                    read_control_go;
  logic                    read_user_read_buffer;
  logic [DATAWIDTH-1:0]    read_user_buffer_output_data;
  logic                    read_user_data_available;

  modport master (
    input  read_control_done, read_user_buffer_output_data, read_user_data_available,
    output read_control_fixed_location, read_control_read_base, read_control_read_length,
           read_control_go, read_user_read_buffer
  );
  modport slave (
    output read_control_done, read_user_buffer_output_data, read_user_data_available,
    input  read_control_fixed_location, read_control_read_base, read_control_read_length,
           read_control_go, read_user_read_buffer
  );
endinterface

interface bce_wr_if #(parameter int ADDRESSWIDTH = 28, parameter int DATAWIDTH = 32);
  logic                    write_control_done;
  logic                    write_control_fixed_location;
  logic [ADDRESSWIDTH-1:0] write_control_write_base;
  logic [ADDRESSWIDTH-1:0] write_control_write_length;
  logic                    write_control_go;
  logic                    write_user_write_buffer;
  logic [DATAWIDTH-1:0]    write_user_buffer_data;
  logic                    write_user_buffer_full;

  modport master (
    input  write_control_done, write_user_buffer_full,
    output write_control_fixed_location, write_control_write_base, write_control_write_length,
           write_control_go, write_user_write_buffer, write_user_buffer_data
  );
  modport slave (
    output write_control_done, write_user_buffer_full,
    input  write_control_fixed_location, write_control_write_base, write_control_write_length,
           write_control_go, write_user_write_buffer, write_user_buffer_data
  );
endinterface

// File: rtl/bce_burst_buf.sv
// Show-ahead synchronous FIFO holding one burst between the read and write
// masters; pop_data always presents the oldest word.
module bce_burst_buf #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] pop_data,
  output logic [7:0]       count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + 8'(push) - 8'(pop);
    end
  end

endmodule

// File: rtl/block_copy_engine.sv
// Polls a marker word and, on a match, copies BLOCK_WORDS words from src to dst
// in bursts. Define BCE_CLEAR_MARKER_EN to zero the marker before block_done.
module block_copy_engine
  import bce_pkg::*;
#(
  parameter int                   ADDRESSWIDTH    = 28,
  parameter int                   DATAWIDTH       = 32,
  parameter int                   BYTEENABLEWIDTH = BYTES_PER_WORD,
  parameter int                   BLOCK_WORDS     = 24,
  parameter int                   BURST_WORDS     = 8,
  parameter logic [DATAWIDTH-1:0] MARKER          = DEFAULT_MARKER,
  parameter int                   POLL_GAP        = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [ADDRESSWIDTH-1:0] marker_addr,
  input  logic [ADDRESSWIDTH-1:0] src_base,
  input  logic [ADDRESSWIDTH-1:0] dst_base,
  output logic                    busy,
  output logic                    block_done,
  output logic [7:0]              block_count,
  output logic [7:0]              word_count,
  bce_rd_if.master                rd,
  bce_wr_if.master                wr
);
  localparam logic [7:0] FIRST_LEN = burst_len(8'(BLOCK_WORDS), 8'(BURST_WORDS));

  bce_state_t              state;
  logic [ADDRESSWIDTH-1:0] src_ptr, dst_ptr, mark_ptr;
  logic [DATAWIDTH-1:0]    poll_word, buf_data;
  logic [7:0]              remaining, len, rem_next, next_len, buf_count;
  logic [15:0]             gap_cnt;
  logic                    rd_fire, wr_fire;
`ifdef BCE_CLEAR_MARKER_EN
  logic                    clr_pushed;
  logic                    clr_push;
`endif

  function automatic logic [ADDRESSWIDTH-1:0] len_bytes(input logic [7:0] n);
    return ADDRESSWIDTH'(n) * ADDRESSWIDTH'(BYTEENABLEWIDTH);
  endfunction

  assign rem_next = remaining - len;
  assign next_len = burst_len(rem_next, 8'(BURST_WORDS));

  // Pops and pushes are qualified combinationally so no word is ever taken
  // from an empty read FIFO or offered to a full write FIFO.
  assign rd_fire = (state == RD_STREAM) && rd.read_user_data_available;
  assign wr_fire = (state == WR_STREAM) && !wr.write_user_buffer_full;

  assign rd.read_control_fixed_location  = 1'b0;
  assign wr.write_control_fixed_location = 1'b0;
  assign rd.read_user_read_buffer        = rd_fire || (state == POLL_POP);
  assign wr.write_user_buffer_data       = (state == WR_STREAM) ? buf_data : '0;
`ifdef BCE_CLEAR_MARKER_EN
  assign clr_push = (state == CLR_WAIT) && !clr_pushed && !wr.write_user_buffer_full;
  assign wr.write_user_write_buffer = wr_fire || clr_push;
`else
  assign wr.write_user_write_buffer = wr_fire;
`endif

  bce_burst_buf #(.DEPTH(BURST_WORDS), .WIDTH(DATAWIDTH)) u_buf (
    .clk       (clk),
    .reset     (reset),
    .push      (rd_fire),
    .pop       (wr_fire),
    .push_data (rd.read_user_buffer_output_data),
    .pop_data  (buf_data),
    .count     (buf_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state                         <= IDLE;
      busy                          <= 1'b0;
      block_done                    <= 1'b0;
      block_count                   <= '0;
      word_count                    <= '0;
      remaining                     <= '0;
      len                           <= '0;
      gap_cnt                       <= '0;
      rd.read_control_go            <= 1'b0;
      rd.read_control_read_base     <= '0;
      rd.read_control_read_length   <= '0;
      wr.write_control_go           <= 1'b0;
      wr.write_control_write_base   <= '0;
      wr.write_control_write_length <= '0;
`ifdef BCE_CLEAR_MARKER_EN
      clr_pushed                    <= 1'b0;
`endif
    end else begin
      rd.read_control_go  <= 1'b0;
      wr.write_control_go <= 1'b0;
      block_done          <= 1'b0;
      case (state)
        IDLE: if (enable) begin
          state                       <= POLL_GO;
          mark_ptr                    <= marker_addr;
          rd.read_control_read_base   <= marker_addr;
          rd.read_control_read_length <= len_bytes(8'd1);
          rd.read_control_go          <= 1'b1;
        end
        POLL_GO:   state <= POLL_WAIT;
        POLL_WAIT: if (rd.read_control_done && rd.read_user_data_available) state <= POLL_POP;
        POLL_POP: begin
          poll_word <= rd.read_user_buffer_output_data;
          state     <= POLL_CHECK;
        end
        POLL_CHECK: if (poll_word == MARKER) begin
          src_ptr                     <= src_base;
          dst_ptr                     <= dst_base;
          busy                        <= 1'b1;
          word_count                  <= '0;
          remaining                   <= 8'(BLOCK_WORDS);
          len                         <= FIRST_LEN;
          state                       <= RD_GO;
          rd.read_control_read_base   <= src_base;
          rd.read_control_read_length <= len_bytes(FIRST_LEN);
          rd.read_control_go          <= 1'b1;
        end else if (POLL_GAP == 0) begin
          state <= IDLE;
        end else begin
          gap_cnt <= 16'(POLL_GAP - 1);
          state   <= GAP;
        end
        GAP: if (gap_cnt == '0) state <= IDLE; else gap_cnt <= gap_cnt - 1'b1;
        RD_GO:     state <= RD_STREAM;
        RD_STREAM: if (rd_fire && buf_count == len - 8'd1) state <= RD_WAIT;
        RD_WAIT: if (rd.read_control_done) begin
          state                         <= WR_GO;
          wr.write_control_write_base   <= dst_ptr;
          wr.write_control_write_length <= len_bytes(len);
          wr.write_control_go           <= 1'b1;
        end
        WR_GO:     state <= WR_STREAM;
        WR_STREAM: if (wr_fire && buf_count == 8'd1) state <= WR_WAIT;
        WR_WAIT: if (wr.write_control_done) begin
          src_ptr    <= src_ptr + len_bytes(len);
          dst_ptr    <= dst_ptr + len_bytes(len);
          word_count <= word_count + len;
          remaining  <= rem_next;
          if (rem_next == '0) begin
`ifdef BCE_CLEAR_MARKER_EN
            state                         <= CLR_GO;
            clr_pushed                    <= 1'b0;
            wr.write_control_write_base   <= mark_ptr;
            wr.write_control_write_length <= len_bytes(8'd1);
            wr.write_control_go           <= 1'b1;
`else
            state       <= DONE;
            block_done  <= 1'b1;
            block_count <= block_count + 8'd1;
            busy        <= 1'b0;
`endif
          end else begin
            len                         <= next_len;
            state                       <= RD_GO;
            rd.read_control_read_base   <= src_ptr + len_bytes(len);
            rd.read_control_read_length <= len_bytes(next_len);
            rd.read_control_go          <= 1'b1;
          end
        end
`ifdef BCE_CLEAR_MARKER_EN
        CLR_GO: state <= CLR_WAIT;
        CLR_WAIT: begin
          if (clr_push) clr_pushed <= 1'b1;
          if (clr_pushed && wr.write_control_done) begin
            state       <= DONE;
            block_done  <= 1'b1;
            block_count <= block_count + 8'd1;
            busy        <= 1'b0;
          end
        end
`endif
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_block_copy_engine.sv
// Bench for block_copy_engine: behavioural read/write masters over a sparse
// SDRAM model, with a scoreboard of expected bursts and destination writes.
module tb_block_copy_engine;
  import bce_pkg::*;

  localparam int          AW    = 28;
  localparam int          DW    = 32;
  localparam int          BLK   = 24;
  localparam int          BUR   = 10;
  localparam int          PGAP  = 4;
  localparam logic [31:0] MARK  = 32'hAAAA0000;
  localparam logic [AW-1:0] MADDR = 28'h0000100;
  localparam logic [AW-1:0] SRC   = 28'h8000004;
  localparam logic [AW-1:0] DST   = 28'h8000090;

  logic          clk = 1'b0;
  logic          reset, enable;
  logic [AW-1:0] marker_addr, src_base, dst_base;
  logic          busy, block_done;
  logic [7:0]    block_count, word_count;

  bce_rd_if #(.ADDRESSWIDTH(AW), .DATAWIDTH(DW)) rd();
  bce_wr_if #(.ADDRESSWIDTH(AW), .DATAWIDTH(DW)) wr();

  block_copy_engine #(
    .ADDRESSWIDTH(AW), .DATAWIDTH(DW), .BYTEENABLEWIDTH(4), .BLOCK_WORDS(BLK),
    .BURST_WORDS(BUR), .MARKER(MARK), .POLL_GAP(PGAP)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .marker_addr(marker_addr),
    .src_base(src_base), .dst_base(dst_base), .busy(busy), .block_done(block_done),
    .block_count(block_count), .word_count(word_count), .rd(rd), .wr(wr)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [AW-1:0] base; logic [AW-1:0] len; } xfer_t;
  typedef struct packed { logic [AW-1:0] addr; logic [31:0] data; } word_t;

  logic [31:0] mem [int];
  logic [31:0] rq [$];
  xfer_t       exp_rd [$], exp_wr [$];
  word_t       exp_wd [$];
  int          poll_times [$];
  int          n_cmp = 0, n_err = 0;
  int          cyc = 0, wr_go_cnt = 0;
  bit          rd_stall = 0, wr_rand = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [AW-1:0] a);
    int k = int'(a >> 2);
    return mem.exists(k) ? mem[k] : 32'h0;
  endfunction

  // Expected bursts and destination words for one block, in order.
  task automatic push_block_exp();
    int off = 0;
    while (off < BLK) begin
      int l = (BLK - off < BUR) ? BLK - off : BUR;
      exp_rd.push_back('{base: SRC + AW'(off * 4), len: AW'(l * 4)});
      exp_wr.push_back('{base: DST + AW'(off * 4), len: AW'(l * 4)});
      off += l;
    end
    for (int i = 0; i < BLK; i++)
      exp_wd.push_back('{addr: DST + AW'(i * 4), data: mem_rd(SRC + AW'(i * 4))});
`ifdef BCE_CLEAR_MARKER_EN
    exp_wr.push_back('{base: MADDR, len: AW'(4)});
    exp_wd.push_back('{addr: MADDR, data: 32'h0});
`endif
  endtask

  // Master models: decisions sampled at negedge, effects applied just after posedge.
  initial begin : masters
    logic          c_rgo, c_pop, c_wgo, c_push;
    logic [AW-1:0] c_rbase, c_rlen, c_wbase, c_wlen;
    logic [31:0]   c_wdata;
    logic [AW-1:0] rd_addr, wr_addr;
    int            rd_left, wr_left;
    xfer_t         x;
    word_t         w;
    rd_left = 0; wr_left = 0; rd_addr = '0; wr_addr = '0;
    rd.read_control_done = 1'b1; rd.read_user_data_available = 1'b0;
    rd.read_user_buffer_output_data = '0;
    wr.write_control_done = 1'b1; wr.write_user_buffer_full = 1'b0;
    forever begin
      @(negedge clk);
      c_rgo = rd.read_control_go;  c_rbase = rd.read_control_read_base;
      c_rlen = rd.read_control_read_length; c_pop = rd.read_user_read_buffer;
      c_wgo = wr.write_control_go; c_wbase = wr.write_control_write_base;
      c_wlen = wr.write_control_write_length;
      c_push = wr.write_user_write_buffer && !wr.write_user_buffer_full;
      c_wdata = wr.write_user_buffer_data;
      @(posedge clk); #1;
      cyc++;
      if (reset) begin
        rq.delete(); rd_left = 0; wr_left = 0;
        rd.read_control_done = 1'b1; wr.write_control_done = 1'b1;
        wr.write_user_buffer_full = 1'b0;
      end else begin
        if (c_pop) begin
          chk("rd_pop_avail", rq.size() != 0, 1'b1);
          if (rq.size() != 0) void'(rq.pop_front());
        end
        if (c_rgo) begin
          if (c_rbase == marker_addr) begin
            chk("poll_len", c_rlen, 4);
            poll_times.push_back(cyc);
          end else begin
            chk("rd_expected", exp_rd.size() != 0, 1'b1);
            if (exp_rd.size() != 0) begin
              x = exp_rd.pop_front();
              chk("rd_base", c_rbase, x.base);
              chk("rd_len", c_rlen, x.len);
            end
          end
          rd_addr = c_rbase; rd_left = int'(c_rlen) / 4; rd.read_control_done = 1'b0;
        end
        if (rd_left > 0 && !(rd_stall && $urandom_range(0, 2) == 0)) begin
          rq.push_back(mem_rd(rd_addr));
          rd_addr += 4; rd_left--;
          if (rd_left == 0) rd.read_control_done = 1'b1;
        end
        if (c_wgo) begin
          wr_go_cnt++;
          chk("wr_expected", exp_wr.size() != 0, 1'b1);
          if (exp_wr.size() != 0) begin
            x = exp_wr.pop_front();
            chk("wr_base", c_wbase, x.base);
            chk("wr_len", c_wlen, x.len);
          end
          wr_addr = c_wbase; wr_left = int'(c_wlen) / 4; wr.write_control_done = 1'b0;
        end
        if (c_push) begin
          chk("wr_in_burst", wr_left > 0, 1'b1);
          chk("wr_data_expected", exp_wd.size() != 0, 1'b1);
          if (exp_wd.size() != 0) begin
            w = exp_wd.pop_front();
            chk("wr_addr", wr_addr, w.addr);
            chk("wr_data", c_wdata, w.data);
          end
          mem[int'(wr_addr >> 2)] = c_wdata;
          wr_addr += 4; wr_left--;
          if (wr_left == 0) wr.write_control_done = 1'b1;
        end
        wr.write_user_buffer_full = wr_rand && ($urandom_range(0, 1) == 1);
      end
      rd.read_user_data_available     = (rq.size() != 0);
      rd.read_user_buffer_output_data = (rq.size() != 0) ? rq[0] : 32'h0;
    end
  end

  task automatic wait_busy(input string tag);
    int n = 0;
    while (!busy && n < 300) begin @(negedge clk); n++; end
    chk(tag, busy, 1'b1);
  endtask

  task automatic run_block_window(input string tag);
    int pulses = 0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if (block_done) pulses++;
    end
    chk({tag, "_done_pulses"}, pulses, 1);
    chk({tag, "_block_count"}, block_count, 1);
    chk({tag, "_word_count"}, word_count, BLK);
    chk({tag, "_busy_after"}, busy, 1'b0);
    chk({tag, "_rd_left"}, exp_rd.size(), 0);
    chk({tag, "_wr_left"}, exp_wr.size(), 0);
    chk({tag, "_wd_left"}, exp_wd.size(), 0);
    for (int i = 0; i < BLK; i++)
      chk({tag, "_dst_eq_src"}, mem_rd(DST + AW'(i * 4)), mem_rd(SRC + AW'(i * 4)));
  endtask

  initial begin : stim
    bit busy_seen;
    int n;
    reset = 1'b1; enable = 1'b0;
    marker_addr = MADDR; src_base = SRC; dst_base = DST;
    mem[int'(MADDR >> 2)] = 32'h12345678;
    for (int i = 0; i < BLK; i++) mem[int'(SRC >> 2) + i] = $urandom;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_block_done", block_done, 1'b0);
    chk("rst_block_count", block_count, 0);
    chk("rst_word_count", word_count, 0);
    chk("rst_rd_go", rd.read_control_go, 1'b0);
    chk("rst_rd_base", rd.read_control_read_base, 0);
    chk("rst_rd_len", rd.read_control_read_length, 0);
    chk("rst_rd_pop", rd.read_user_read_buffer, 1'b0);
    chk("rst_wr_go", wr.write_control_go, 1'b0);
    chk("rst_wr_base", wr.write_control_write_base, 0);
    chk("rst_wr_push", wr.write_user_write_buffer, 1'b0);
    chk("rst_fixed", {rd.read_control_fixed_location, wr.write_control_fixed_location}, 0);

    // Non-matching marker: repeated polls, never busy, never a write.
    reset = 1'b0; enable = 1'b1;
    busy_seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      busy_seen |= busy;
    end
    chk("nomatch_busy", busy_seen, 1'b0);
    chk("nomatch_writes", wr_go_cnt, 0);
    chk("nomatch_polls", poll_times.size() >= 4, 1'b1);
    // GO, WAIT (data ready after one cycle), POP, CHECK, PGAP gap cycles, IDLE.
    for (int i = 1; i < 4 && i < poll_times.size(); i++)
      chk("poll_period", poll_times[i] - poll_times[i-1], PGAP + 5);

    // Matching marker: full block with read stalls and random write backpressure.
    push_block_exp();
    rd_stall = 1; wr_rand = 1;
    mem[int'(MADDR >> 2)] = MARK;
    wait_busy("copy_busy");
`ifndef BCE_CLEAR_MARKER_EN
    mem[int'(MADDR >> 2)] = 32'h0;
`endif
    run_block_window("copy");
    chk("marker_after_copy", mem_rd(MADDR), 32'h0);

    // Reset while streaming reads, then a fresh block must copy cleanly.
    push_block_exp();
    mem[int'(MADDR >> 2)] = MARK;
    wait_busy("rst_busy_pre");
    n = 0;
    while (!(busy && rd.read_user_read_buffer) && n < 300) begin @(negedge clk); n++; end
    chk("rst_in_rd_stream", busy && rd.read_user_read_buffer, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    exp_rd.delete(); exp_wr.delete(); exp_wd.delete();
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_block_count", block_count, 0);
    chk("midrst_word_count", word_count, 0);
    chk("midrst_rd_go", rd.read_control_go, 1'b0);
    chk("midrst_rd_base", rd.read_control_read_base, 0);
    chk("midrst_rd_pop", rd.read_user_read_buffer, 1'b0);
    chk("midrst_wr_base", wr.write_control_write_base, 0);
    push_block_exp();
    reset = 1'b0;
    wait_busy("post_rst_busy");
`ifndef BCE_CLEAR_MARKER_EN
    mem[int'(MADDR >> 2)] = 32'h0;
`endif
    run_block_window("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/block_copy_engine.md
Name: block_copy_engine

Overview:
- Parametrised successor to the single-word mailbox poller.
- Polls a marker word in SDRAM through the read master. When the marker is found, copies a block of BLOCK_WORDS words from a source region to a destination region.
- Transfers use multi-word bursts through the read and write master control/user interfaces.
- Sits between the Avalon read/write masters and the miner core's work-fetch logic. Reports status for the display and core.

Parameters:
ADDRESSWIDTH, 28, byte address width of both masters
DATAWIDTH, 32, data word width in bits
BYTEENABLEWIDTH, 4, bytes per word (DATAWIDTH/8)
BLOCK_WORDS, 24, words copied per detected block (1..255)
BURST_WORDS, 8, maximum words per read/write burst (1..BLOCK_WORDS), also the buffer depth
MARKER, 32'hAAAA0000, value that signals a pending block
POLL_GAP, 16, idle cycles between unsuccessful polls (0 allowed)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
enable  in  1  polling permitted while high; a copy in progress always completes
marker_addr  in  ADDRESSWIDTH  byte address of marker word, sampled at each poll start
src_base  in  ADDRESSWIDTH  first source byte address, latched on marker match
dst_base  in  ADDRESSWIDTH  first destination byte address, latched on marker match
busy  out  1  high from marker match until block done
block_done  out  1  one-cycle pulse when last destination write completes
block_count  out  8  blocks completed, wraps 255->0
word_count  out  8  words written in current block
read_control_done  in  1  read master done (held)
read_control_fixed_location  out  1  constant 0
read_control_read_base  out  ADDRESSWIDTH  read base address
read_control_read_length  out  ADDRESSWIDTH  read byte length
read_control_go  out  1  start read, one-cycle pulse
read_user_read_buffer  out  1  pop read FIFO
read_user_buffer_output_data  in  DATAWIDTH  read data
read_user_data_available  in  1  read data valid
write_control_done  in  1  write master done (held)
write_control_fixed_location  out  1  constant 0
write_control_write_base  out  ADDRESSWIDTH  write base address
write_control_write_length  out  ADDRESSWIDTH  write byte length
write_control_go  out  1  start write, one-cycle pulse
write_user_write_buffer  out  1  push write data
write_user_buffer_data  out  DATAWIDTH  write data
write_user_buffer_full  in  1  write FIFO full

Behaviour:
- Reset: state IDLE, all outputs 0, counters 0, buffer empty.
- Reset mid-transfer is synchronous and abandons the transfer. The masters share the same reset.
- States: IDLE, POLL_GO, POLL_WAIT, POLL_POP, POLL_CHECK, GAP, RD_GO, RD_STREAM, RD_WAIT, WR_GO, WR_STREAM, WR_WAIT, DONE.
- IDLE -> POLL_GO when enable is high.
- POLL_GO: read_control_go=1, base=marker_addr, length=BYTEENABLEWIDTH. Next state POLL_WAIT.
- POLL_WAIT: wait for read_control_done and read_user_data_available, then POLL_POP.
- POLL_POP: pop one word and register it. Next state POLL_CHECK.
- POLL_CHECK on a match:
  - latch src_base and dst_base
  - set busy
  - clear word_count and the remaining-word counter (remaining = BLOCK_WORDS)
  - next state RD_GO
- POLL_CHECK on a mismatch: GAP, counting POLL_GAP cycles, then IDLE.
- Burst length: len = min(remaining, BURST_WORDS). The final burst is the partial remainder, e.g. 24/8 gives 3x8 and 24/10 gives 10,10,4.
- RD_GO: go pulse, base=src pointer, length=len*BYTEENABLEWIDTH.
- RD_STREAM: pop a word each cycle read_user_data_available is high, writing it into the buffer, until len words are captured. Never pop while the flag is low.
- RD_WAIT: wait for read_control_done (it may already be high). Next state WR_GO.
- WR_GO: go pulse, base=dst pointer, same length.
- WR_STREAM: push one buffer word per cycle while write_user_buffer_full is low. When full is high, hold data and write_user_write_buffer=0; no word is lost or duplicated.
- WR_WAIT: wait for write_control_done. Then:
  - advance src and dst by len*BYTEENABLEWIDTH, wrapping modulo 2^ADDRESSWIDTH
  - word_count += len
  - remaining -= len
  - if remaining == 0 go to DONE, else RD_GO
- DONE: block_done=1 for one cycle, block_count++, busy=0. Next state IDLE.
- enable low during a copy is ignored until IDLE.
- Output latency: go pulses occur in the cycle the state is entered. Data words are never reordered.
- Address and length outputs hold their values outside the go cycles.

Optional Feature:
- BCE_CLEAR_MARKER_EN defined:
  - DONE is preceded by CLR_GO/CLR_WAIT, a one-word write of 32'h0 to the latched marker address.
  - block_done pulses only after that write's write_control_done.
  - This prevents re-copying the same block.
- Undefined: marker is left untouched. The host must clear it, otherwise the next poll re-triggers the copy.

Decomposition:
- Package bce_pkg holds:
  - the state enum (bce_state_t)
  - BYTES_PER_WORD
  - the default MARKER constant
  - a min/length helper function
- Sub-module bce_burst_buf: synchronous FIFO, depth BURST_WORDS, DATAWIDTH wide, with push/pop/count.

Test Plan:
- Marker word 32'h12345678, enable=1, POLL_GAP=4 -> a poll every 4+handshake cycles, no copy, busy stays 0.
- Marker 32'hAAAA0000, BLOCK_WORDS=24, BURST_WORDS=8, src=0x8000004, dst=0x8000090:
  - 3 reads and 3 writes, each length 32, with bases advancing by 32
  - destination equals source
  - block_done pulses once, block_count=1
- BURST_WORDS=10 with 24 words -> lengths 40, 40, 16; word_count ends at 24.
- write_user_buffer_full toggled randomly during WR_STREAM -> every word written exactly once, in order.
- Reset asserted in RD_STREAM -> next cycle state IDLE, outputs 0, counters 0; a subsequent poll works.
- With BCE_CLEAR_MARKER_EN, one block -> marker address reads 0 afterwards and a second poll does not copy.
